hex_text_arbiter: RTL

- Shares one single-port character RAM between a CPU access port and the video fetch engine of the hex text display.
- Prefetches the code of the next character cell ahead of the beam and presents the current cell's code to the font decoder as `digit`.
- Sits between the scaled-timing generator (`hpos`/`vpos`/`display_on`), the character RAM and the hex font ROM.
- Video fetches have strict priority; the CPU is stalled through a req/ack handshake.

---
 rtl/hex_text_arbiter_pkg.sv | 29 ++
 rtl/hex_text_arbiter_if.sv | 26 ++
 rtl/hex_text_arbiter_video_fetch_gen.sv | 57 +++++
 rtl/hex_text_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/hex_text_arbiter_pkg.sv
// Shared constants, FSM state type and cell address helper for the hex text
// display character RAM arbiter.
package hex_text_arbiter_pkg;

  localparam int COLS   = 20;
  localparam int ROWS   = 15;
  localparam int CELL_W = 8;
  localparam int ADDR_W = 9;
  localparam int CODE_W = 4;

  localparam logic [2:0] FETCH_X = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VRD,
    ST_VWAIT,
    ST_CWR,
    ST_CRD,
    ST_CWAIT
  } state_t;

  // Linear cell index in ADDR_W-bit arithmetic.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] row, input logic [4:0] col);
    logic [ADDR_W-1:0] w_row;
    w_row = ADDR_W'(row);
    return w_row * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/hex_text_arbiter_if.sv
// CPU access port and character RAM port of the arbiter, bundled as one interface.
interface hex_text_arbiter_if;
  import hex_text_arbiter_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [CODE_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [CODE_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [CODE_W-1:0] ram_wdata;
  logic [CODE_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );

endinterface

// File: rtl/hex_text_arbiter_video_fetch_gen.sv
// Turns beam position changes into video fetch requests (next cell or first
// cell of the next line) and the strobe that hands the prefetched code over.
module hex_text_arbiter_video_fetch_gen
  import hex_text_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        hpos,
  input  logic [6:0]        vpos,
  input  logic              display_on,
  output logic              vreq,
  output logic [ADDR_W-1:0] vaddr,
  output logic              handoff
);

  logic [7:0] r_hpos_prev;
  logic       r_disp_prev;

  logic       w_hpos_chg;
  logic [4:0] w_col;
  logic [3:0] w_row;
  logic [6:0] w_vpos_nx;
  logic       w_cell_evt;
  logic       w_line_evt;
  logic       w_last_line;
  logic [ADDR_W-1:0] w_line_addr;
  logic [ADDR_W-1:0] w_cell_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hpos_prev <= '0;
      r_disp_prev <= 1'b0;
    end else begin
      r_hpos_prev <= hpos;
      r_disp_prev <= display_on;
    end
  end

  assign w_hpos_chg  = (hpos != r_hpos_prev);
  assign w_col       = hpos[7:3];
  assign w_row       = vpos[6:3];
  assign w_vpos_nx   = vpos + 7'd1;
  assign w_last_line = (vpos == 7'(ROWS*CELL_W-1));

  // The last column has no right neighbour; its successor comes from the line fetch.
  assign w_cell_evt  = display_on && w_hpos_chg && (hpos[2:0] == FETCH_X) &&
                       (w_col != 5'(COLS-1));
  assign w_line_evt  = r_disp_prev && !display_on;

  assign w_cell_next = cell_addr(w_row, w_col) + ADDR_W'(1);
  assign w_line_addr = w_last_line ? '0 : cell_addr(w_vpos_nx[6:3], 5'd0);

  assign vreq    = w_cell_evt || w_line_evt;
  assign vaddr   = w_line_evt ? w_line_addr : w_cell_next;
  assign handoff = display_on && ((w_hpos_chg && (hpos[2:0] == 3'd0)) || !r_disp_prev);

endmodule

// File: rtl/hex_text_arbiter.sv
// Character RAM arbiter: video prefetch has strict priority, CPU waits on req/ack.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | RAM free; pick pending video fetch, else CPU
// ST_VRD   | video read address on RAM
// ST_VWAIT | video read data returns into next_code
// ST_CWR   | CPU write cycle, ack pulsed
// ST_CRD   | CPU read address on RAM
// ST_CWAIT | CPU read data returned, ack pulsed
module hex_text_arbiter
  import hex_text_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         hpos,
  input  logic [6:0]         vpos,
  input  logic               display_on,
  hex_text_arbiter_if.slave  bus,
  output logic [CODE_W-1:0]  digit,
  output logic               vid_miss
);

  state_t r_state;
  state_t w_state_nx;

  logic              r_vpending;
  logic [ADDR_W-1:0] r_vaddr;
  logic              r_vid_miss;
  logic [CODE_W-1:0] r_next_code;
  logic [CODE_W-1:0] r_cur_code;

  logic              w_vreq;
  logic [ADDR_W-1:0] w_vaddr;
  logic              w_handoff;

  hex_text_arbiter_video_fetch_gen u_vfetch (
    .clk        (clk),
    .reset      (reset),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .vreq       (w_vreq),
    .vaddr      (w_vaddr),
    .handoff    (w_handoff)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_vpending  <= 1'b0;
      r_vaddr     <= '0;
      r_vid_miss  <= 1'b0;
      r_next_code <= '0;
      r_cur_code  <= '0;
    end else begin
      r_state <= w_state_nx;
      // A fresh event overrides the clear in VRD so back-to-back requests survive.
      if (w_vreq) begin
        r_vpending <= 1'b1;
        r_vaddr    <= w_vaddr;
      end else if (r_state == ST_VRD) begin
        r_vpending <= 1'b0;
      end
      if (w_vreq && r_vpending && (r_state != ST_VRD))
        r_vid_miss <= 1'b1;
      if (r_state == ST_VWAIT)
        r_next_code <= bus.ram_rdata;
      if (w_handoff)
        r_cur_code <= r_next_code;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    bus.cpu_ack   = 1'b0;
    bus.cpu_rdata = '0;
    case (r_state)
      ST_IDLE: begin
        // The event arriving this cycle counts, so video beats a simultaneous CPU request.
        if (r_vpending || w_vreq)
          w_state_nx = ST_VRD;
        else if (bus.cpu_req)
          w_state_nx = bus.cpu_we ? ST_CWR : ST_CRD;
      end
      ST_VRD: begin
        bus.ram_addr = r_vaddr;
        w_state_nx   = ST_VWAIT;
      end
      ST_VWAIT: begin
        w_state_nx = ST_IDLE;
      end
      ST_CWR: begin
        bus.ram_addr  = bus.cpu_addr;
        bus.ram_wdata = bus.cpu_wdata;
        bus.ram_we    = 1'b1;
        bus.cpu_ack   = 1'b1;
        w_state_nx    = ST_IDLE;
      end
      ST_CRD: begin
        bus.ram_addr = bus.cpu_addr;
        w_state_nx   = ST_CWAIT;
      end
      ST_CWAIT: begin
        bus.cpu_rdata = bus.ram_rdata;
        bus.cpu_ack   = 1'b1;
        w_state_nx    = ST_IDLE;
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign digit    = r_cur_code;
  assign vid_miss = r_vid_miss;

endmodule
